uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- UART-driven program/data loader that acts as master m1 on the system bus, the currently unused second master port.
- Receives framed word writes from a host over a serial line and drives single-cycle bus writes into dmem through the bus arbiter.
- Holds the core in reset until the host sends GO, so images can be loaded before execution starts.
- Instantiated at SoC top next to the core; core_hold_o is ORed into the core's reset.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 16..65535.
- SYNC_STAGES, 2, rx_i synchronizer depth; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rx_i  in  1  UART receive line, 8N1, idle high
- m1_un_sign_o  out  1  always `UNSIGNED
- m1_byte_mask_o  out  BYTE_SEL  `SL_WORD during write strobe, else `SL_NONE
- m1_re_o  out  1  always `READ_DISABLE (loader never reads)
- m1_we_o  out  1  one-cycle write strobe
- m1_addr_o  out  MEM_ADDR_WIDTH  write address, held until next frame
- m1_wdata_o  out  DATA_WIDTH  write data, held until next frame
- core_hold_o  out  1  1 = keep core in reset
- busy_o  out  1  frame in progress (FSM not in S_CMD/S_RUN)
- err_o  out  1  sticky error flag; cleared by the next valid CMD byte

Behaviour:
- Reset values: m1_we_o=0, m1_re_o=0, m1_byte_mask_o=`SL_NONE, m1_addr_o=0, m1_wdata_o=0, core_hold_o=1, busy_o=0, err_o=0, FSM=S_CMD.
- RX byte path (sub-module):
  - rx_i passes through the SYNC_STAGES flops.
  - Falling edge in idle starts a bit counter; the start bit is re-sampled at CLK_DIV/2.
  - If the start bit reads high, the event is a glitch: return to idle, no byte.
  - Data bits are sampled every CLK_DIV cycles after that, LSB first.
  - The stop bit is sampled the same way. Stop=1 gives a one-cycle byte_vld with byte[7:0]; stop=0 gives a one-cycle frame_err and no byte.
- Frame FSM, advancing only on byte_vld:
  - S_CMD: 0xA5 clears err_o and moves to S_ADDR with cnt=0. 0x5A (GO) clears err_o, drops core_hold_o next cycle and moves to S_RUN. Any other byte is ignored.
  - S_ADDR: shift byte into addr[8*cnt+:8] (little-endian); when cnt=3, move to S_DATA with cnt=0.
  - S_DATA: same shifting into the data word; when cnt=3, move to S_WR (or S_CK when the optional feature is compiled in).
  - S_WR, exactly one clk, no byte needed: if addr[1:0]==0, m1_we_o=1 and m1_byte_mask_o=`SL_WORD for this cycle only, with addr and data presented. Otherwise no strobe and err_o=1. Then return to S_CMD.
  - S_RUN: core_hold_o=0. Byte 0xC3 (HALT) sets core_hold_o=1 next cycle and moves to S_CMD. All other bytes are ignored.
- The bus arbiter is combinational for m1 writes, so there is no handshake: the strobe is fire-and-forget. Arbitration loss is impossible while core_hold_o=1. Writes are only accepted in S_CMD, i.e. with the core held.
- A frame_err in S_ADDR, S_DATA or S_CK sets err_o=1 and aborts to S_CMD with no write. A frame_err in S_CMD or S_RUN sets err_o and leaves the state unchanged.
- No inter-byte timeout. Back-to-back frames are legal: S_WR takes 1 cycle, far shorter than one UART byte.
- Async rst mid-frame discards the partial frame and reasserts core_hold_o immediately (combinationally from the flop reset).

Optional Feature:
- Macro LOADER_CKSUM_EN defined:
  - Adds state S_CK, which takes one more byte after data.
  - The received byte must equal the 8-bit sum mod 256 of the 8 address and data bytes.
  - Match: go to S_WR.
  - Mismatch: err_o=1, no write, return to S_CMD.
- Macro undefined: S_DATA goes directly to S_WR, and no checksum logic is synthesized.

Decomposition:
- Add to defines.v: `LDR_CMD_WR 8'hA5, `LDR_CMD_GO 8'h5A, `LDR_CMD_HALT 8'hC3, and `SL_WORD / `SL_NONE if not already present.
- Frame FSM state encodings stay localparams inside uart_loader.
- One sub-module: uart_rx_byte (synchronizer, bit timer, 8N1 deserializer; outputs byte_vld, byte, frame_err).

Test Plan:
- Reset: after rst, core_hold_o=1, m1_we_o=0, err_o=0. With no rx activity for 10 bit times, outputs stay unchanged.
- Word write: send A5 00 01 00 00 EF BE AD DE. Expect exactly one cycle of m1_we_o=1 with addr=0x00000100, wdata=0xDEADBEEF and mask `SL_WORD.
- Misaligned write: send A5 02 00 00 00 11 22 33 44. Expect no m1_we_o pulse and err_o=1. Then send 5A: err_o clears and core_hold_o goes 0.
- Framing error: in the byte after A5 00, force stop bit=0. Expect err_o=1, FSM back to S_CMD; a following valid frame writes normally.
- GO/HALT/run: send 5A, then A5 (ignored in S_RUN), then C3. Expect core_hold_o 0 then 1 and no writes.
- Checksum (LOADER_CKSUM_EN): address 0x00000010, data 0x00000001, checksum 0x11. Expect a write. Repeat with checksum 0x12: expect err_o=1 and no write.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART loader: bus encodings, loader command bytes
// and the RX deserializer state type.
package uart_loader_pkg;
  localparam int DATA_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int BYTE_SEL       = 4;

  localparam logic [BYTE_SEL-1:0] SL_WORD = 4'b1111;
  localparam logic [BYTE_SEL-1:0] SL_NONE = 4'b0000;
  localparam logic UNSIGNED     = 1'b1;
  localparam logic READ_DISABLE = 1'b0;

  localparam logic [7:0] LDR_CMD_WR   = 8'hA5;
  localparam logic [7:0] LDR_CMD_GO   = 8'h5A;
  localparam logic [7:0] LDR_CMD_HALT = 8'hC3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: input synchronizer, bit timer and deserializer.
// Emits a one-cycle byte_vld with the byte, or a one-cycle frame_err on a bad stop bit.
module uart_rx_byte import uart_loader_pkg::*; #(
  parameter int CLK_DIV     = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output rx_state_t  dbg_state
);
  localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  rx_state_t              state_q, state_d;
  logic [15:0]            tmr_q, tmr_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   vld_d, ferr_d;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign byte_data = shift_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
      state_q   <= RX_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      byte_vld  <= vld_d;
      frame_err <= ferr_d;
    end
  end

  // Only a true high-to-low edge starts a byte, so a line held low after a
  // bad stop bit cannot retrigger the receiver.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmr_d = '0;
        if (rx_prev_q && !rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (tmr_q == HALF_END) begin
          tmr_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (tmr_q == BIT_END) begin
          tmr_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (tmr_q == BIT_END) begin
          tmr_d   = '0;
          state_d = RX_IDLE;
          vld_d   = rx_s;
          ferr_d  = !rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_loader.sv
// UART program/data loader acting as bus master m1; holds the core in reset until GO.
// Define LOADER_CKSUM_EN to require a trailing 8-bit checksum byte on every write frame.
module uart_loader import uart_loader_pkg::*; #(
  parameter int CLK_DIV     = 434,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic                      m1_un_sign_o,
  output logic [BYTE_SEL-1:0]       m1_byte_mask_o,
  output logic                      m1_re_o,
  output logic                      m1_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] m1_addr_o,
  output logic [DATA_WIDTH-1:0]     m1_wdata_o,
  output logic                      core_hold_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [4:0]                dbg_state
);
  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CK   = 3'd3,
    S_WR   = 3'd4,
    S_RUN  = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       data_q, data_d;
  logic                        err_q, err_d;
  logic                        hold_q, hold_d;
  logic                        byte_vld, frame_err;
  logic [7:0]                  byte_data;
  rx_state_t                   rx_state;
`ifdef LOADER_CKSUM_EN
  logic [7:0]                  sum_q, sum_d;
`endif

  uart_rx_byte #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .dbg_state (rx_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CMD;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
`ifdef LOADER_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
`ifdef LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    hold_d  = hold_q;
`ifdef LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_CMD: begin
        if (frame_err) begin
          err_d = 1'b1;
        end else if (byte_vld && byte_data == LDR_CMD_WR) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ADDR;
`ifdef LOADER_CKSUM_EN
          sum_d   = '0;
`endif
        end else if (byte_vld && byte_data == LDR_CMD_GO) begin
          err_d   = 1'b0;
          hold_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_ADDR: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else if (byte_vld) begin
          addr_d[8*cnt_q +: 8] = byte_data;
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CKSUM_EN
          sum_d = sum_q + byte_data;
`endif
          if (cnt_q == 2'd3) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else if (byte_vld) begin
          data_d[8*cnt_q +: 8] = byte_data;
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CKSUM_EN
          sum_d = sum_q + byte_data;
          if (cnt_q == 2'd3) state_d = S_CK;
`else
          if (cnt_q == 2'd3) state_d = S_WR;
`endif
        end
      end
`ifdef LOADER_CKSUM_EN
      S_CK: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_CMD;
        end else if (byte_vld) begin
          if (byte_data == sum_q) begin
            state_d = S_WR;
          end else begin
            err_d   = 1'b1;
            state_d = S_CMD;
          end
        end
      end
`endif
      S_WR: begin
        // The strobe itself is decoded from this state; only the error is registered.
        state_d = S_CMD;
        if (addr_q[1:0] != 2'b00) err_d = 1'b1;
      end
      S_RUN: begin
        if (frame_err) begin
          err_d = 1'b1;
        end else if (byte_vld && byte_data == LDR_CMD_HALT) begin
          hold_d  = 1'b1;
          state_d = S_CMD;
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  assign m1_we_o        = (state_q == S_WR) && (addr_q[1:0] == 2'b00);
  assign m1_byte_mask_o = m1_we_o ? SL_WORD : SL_NONE;
  assign m1_un_sign_o   = UNSIGNED;
  assign m1_re_o        = READ_DISABLE;
  assign m1_addr_o      = addr_q;
  assign m1_wdata_o     = data_q;
  assign core_hold_o    = hold_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != S_CMD) && (state_q != S_RUN);
  assign dbg_state      = {rx_state, state_q};
endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: byte-level host model, write scoreboard and status checks.
`timescale 1ns/1ps
module tb_uart_loader;
  import uart_loader_pkg::*;

  localparam int CLK_DIV = 16;
`ifdef LOADER_CKSUM_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      rx_i = 1'b1;
  logic                      m1_un_sign_o;
  logic [BYTE_SEL-1:0]       m1_byte_mask_o;
  logic                      m1_re_o;
  logic                      m1_we_o;
  logic [MEM_ADDR_WIDTH-1:0] m1_addr_o;
  logic [DATA_WIDTH-1:0]     m1_wdata_o;
  logic                      core_hold_o;
  logic                      busy_o;
  logic                      err_o;
  logic [4:0]                dbg_state;

  uart_loader #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_i           (rx_i),
    .m1_un_sign_o   (m1_un_sign_o),
    .m1_byte_mask_o (m1_byte_mask_o),
    .m1_re_o        (m1_re_o),
    .m1_we_o        (m1_we_o),
    .m1_addr_o      (m1_addr_o),
    .m1_wdata_o     (m1_wdata_o),
    .core_hold_o    (core_hold_o),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // Host-side view of the loader: held/err flags plus the bytes of the frame being collected.
  bit         m_hold = 1'b1;
  bit         m_err = 1'b0;
  bit         m_in_frame = 1'b0;
  logic [7:0] m_frame[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = 1'b1;
    m_err = 1'b0;
    m_in_frame = 1'b0;
    m_frame.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit bad);
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  s;
    bit          ok;
    if (bad) begin
      m_err = 1'b1;
      m_in_frame = 1'b0;
      m_frame.delete();
    end else if (m_in_frame) begin
      m_frame.push_back(b);
      if (m_frame.size() == FRAME_LEN) begin
        a = {m_frame[3], m_frame[2], m_frame[1], m_frame[0]};
        d = {m_frame[7], m_frame[6], m_frame[5], m_frame[4]};
        s = '0;
        for (int i = 0; i < 8; i++) s = s + m_frame[i];
        ok = (a % 4 == 0);
        if (FRAME_LEN == 9 && s != m_frame[8]) ok = 1'b0;
        if (ok) exp_q.push_back({a, d});
        else m_err = 1'b1;
        m_in_frame = 1'b0;
        m_frame.delete();
      end
    end else if (!m_hold) begin
      if (b == 8'hC3) m_hold = 1'b1;
    end else if (b == 8'hA5) begin
      m_err = 1'b0;
      m_in_frame = 1'b1;
    end else if (b == 8'h5A) begin
      m_err = 1'b0;
      m_hold = 1'b0;
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_err_o"}, 64'(err_o), 64'(m_err));
    check({tag, "_core_hold_o"}, 64'(core_hold_o), 64'(m_hold));
    check({tag, "_busy_o"}, 64'(busy_o), 64'(m_in_frame));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && m1_we_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", m1_addr_o, m1_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(m1_addr_o), 64'(e[63:32]));
        check("write_data", 64'(m1_wdata_o), 64'(e[31:0]));
        check("write_mask", 64'(m1_byte_mask_o), 64'(SL_WORD));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    model_byte(b, bad_stop);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_i = !bad_stop;
    repeat (CLK_DIV) @(negedge clk);
    rx_i = 1'b1;
    repeat ($urandom_range(4, 12)) @(negedge clk);
    check_status("byte");
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] s;
    s = '0;
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_byte(a[8*i +: 8], 1'b0);
      s = s + a[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(d[8*i +: 8], 1'b0);
      s = s + d[8*i +: 8];
    end
    if (FRAME_LEN == 9) send_byte(s, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_i = 1'b1;
    #1;
    check("rst_async_hold", 64'(core_hold_o), 64'd1);
    check("rst_async_busy", 64'(busy_o), 64'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("post_rst");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    int          k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_we", 64'(m1_we_o), 64'd0);
    check("rst_re", 64'(m1_re_o), 64'd0);
    check("rst_mask", 64'(m1_byte_mask_o), 64'(SL_NONE));
    check("rst_addr", 64'(m1_addr_o), 64'd0);
    check("rst_wdata", 64'(m1_wdata_o), 64'd0);
    check("rst_un_sign", 64'(m1_un_sign_o), 64'd1);
    check("rst_frame_state", 64'(dbg_state), 64'd0);
    check_status("rst");
    repeat (10 * CLK_DIV) @(negedge clk);
    check("idle_we", 64'(m1_we_o), 64'd0);
    check("idle_addr", 64'(m1_addr_o), 64'd0);
    check_status("idle");

    // word write
    send_frame(32'h0000_0100, 32'hDEAD_BEEF);
    // misaligned write, then GO clears the error
    send_frame(32'h0000_0002, 32'h4433_2211);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hC3, 1'b0);
    // framing error inside the address field, then a clean frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    check("ferr_frame_state", 64'(dbg_state[2:0]), 64'd0);
    send_frame(32'h0000_0200, 32'h1234_5678);
    // short low glitch is not a start bit
    @(negedge clk);
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("glitch_rx_idle", 64'(dbg_state[4:3]), 64'(RX_IDLE));
    check_status("glitch");
    // GO / ignored bytes in run / HALT
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hC3, 1'b0);
    // reset mid-frame and reset while running
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    do_reset();
    send_byte(8'h5A, 1'b0);
    do_reset();
    send_frame(32'h0000_0300, 32'hCAFE_F00D);

`ifdef LOADER_CKSUM_EN
    send_frame(32'h0000_0010, 32'h0000_0001);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    check("cksum_bad_err", 64'(err_o), 64'd1);
`endif

    // randomized traffic
    for (int it = 0; it < 15; it++) begin
      kind = $urandom_range(0, 7);
      if (kind == 0) begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
      end else if (kind == 1) begin
        if (!m_hold) send_byte(8'hC3, 1'b0);
        send_byte(8'hA5, 1'b0);
        k = $urandom_range(0, FRAME_LEN - 1);
        for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        if (!m_hold) send_byte(8'hC3, 1'b0);
        a = $urandom();
        d = $urandom();
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        send_frame(a, d);
      end
    end

    repeat (20) @(negedge clk);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
